// File: rtl/mul_share_arb_if.sv
// Bus between two requesters and the shared 4x4 multiplier arbiter.
// Requests are held levels and each one completes with a single-cycle done pulse.
interface mul_share_arb_if;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       done0;
  logic       done1;
  logic [7:0] prod;
  logic       prod_valid;
  logic       prod_id;
  logic       busy;
  logic [1:0] dbg_state;

  // Handshake: a requester raises reqN with aN/bN valid and keeps all three stable
  // until doneN pulses for one cycle. It then drops reqN in that DONE cycle, or the
  // still-high level is taken as a fresh request in the following IDLE cycle.
  // prod/prod_id are valid while prod_valid is high, and they hold until the next DONE.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  done0, done1, prod, prod_valid, prod_id, busy, dbg_state
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output done0, done1, prod, prod_valid, prod_id, busy, dbg_state
  );
endinterface

// File: rtl/mul_share_arb.sv
// Two-requester round-robin arbiter around a shared 4x4 multiplier.
// The multiplier settles over LAT BUSY cycles, and the product is registered on entry to DONE.
module mul_share_arb #(
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mul_share_arb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       win_q, win_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] prod_q, prod_d;
  logic       prod_id_q, prod_id_d;
  logic       gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      win_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      prod_q     <= 8'd0;
      prod_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      win_q      <= win_d;
      last_gnt_q <= last_gnt_d;
      prod_q     <= prod_d;
      prod_id_q  <= prod_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    win_d      = win_q;
    last_gnt_d = last_gnt_q;
    prod_d     = prod_q;
    prod_id_d  = prod_id_q;
    gnt        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie, the requester that was not granted last time wins.
          gnt        = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
          win_d      = gnt;
          last_gnt_d = gnt;
          a_d        = gnt ? bus.a1 : bus.a0;
          b_d        = gnt ? bus.b1 : bus.b0;
          cnt_d      = CNT_LOAD;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          prod_d    = {4'd0, a_q} * {4'd0, b_q};
          prod_id_d = win_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.done0      = (state_q == S_DONE) && !win_q;
  assign bus.done1      = (state_q == S_DONE) &&  win_q;
  assign bus.prod_valid = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.prod       = prod_q;
  assign bus.prod_id    = prod_id_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with LAT=2.
// Its expected values are hand-computed products, edge counts and grant order.
module tb_mul_share_arb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   edges;
  logic saw_done;

  mul_share_arb_if bus_if ();

  mul_share_arb #(.LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge, then settle so that outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until the selected done pulse is observed. A result of 99 means timeout.
  task automatic wait_done(input bit which, output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((which ? bus_if.done1 : bus_if.done0) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_req(input logic r0, input logic [3:0] x0, input logic [3:0] y0,
                         input logic r1, input logic [3:0] x1, input logic [3:0] y1);
    bus_if.req0 = r0; bus_if.a0 = x0; bus_if.b0 = y0;
    bus_if.req1 = r1; bus_if.a1 = x1; bus_if.b1 = y1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    set_req(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    // reset state
    check("rst_done0", {15'd0, bus_if.done0}, 16'd0);
    check("rst_done1", {15'd0, bus_if.done1}, 16'd0);
    check("rst_prod", {8'd0, bus_if.prod}, 16'd0);
    check("rst_valid", {15'd0, bus_if.prod_valid}, 16'd0);
    check("rst_id", {15'd0, bus_if.prod_id}, 16'd0);
    check("rst_busy", {15'd0, bus_if.busy}, 16'd0);
    check("rst_state", {14'd0, bus_if.dbg_state}, 16'd0);
    rst = 1'b0;

    // single request 3*2
    set_req(1'b1, 4'd3, 4'd2, 1'b0, 4'd0, 4'd0);
    wait_done(1'b0, edges);
    check("single_lat", 16'(edges), 16'd3);
    check("single_prod", {8'd0, bus_if.prod}, 16'd6);
    check("single_id", {15'd0, bus_if.prod_id}, 16'd0);
    check("single_valid", {15'd0, bus_if.prod_valid}, 16'd1);
    check("single_done1", {15'd0, bus_if.done1}, 16'd0);
    bus_if.req0 = 1'b0;
    tick();
    check("single_valid_drop", {15'd0, bus_if.prod_valid}, 16'd0);
    check("single_prod_hold", {8'd0, bus_if.prod}, 16'd6);
    check("single_busy_drop", {15'd0, bus_if.busy}, 16'd0);

    // tie from reset: requester 0 first, then 1
    rst = 1'b1;
    set_req(1'b1, 4'd15, 4'd1, 1'b1, 4'd5, 4'd5);
    tick();
    check("tie_rst_busy", {15'd0, bus_if.busy}, 16'd0);
    rst = 1'b0;
    wait_done(1'b0, edges);
    check("tie_first_lat", 16'(edges), 16'd3);
    check("tie_first_prod", {8'd0, bus_if.prod}, 16'd15);
    check("tie_first_id", {15'd0, bus_if.prod_id}, 16'd0);
    check("tie_first_excl", {15'd0, bus_if.done1}, 16'd0);
    bus_if.req0 = 1'b0;
    wait_done(1'b1, edges);
    check("tie_second_lat", 16'(edges), 16'd4);
    check("tie_second_prod", {8'd0, bus_if.prod}, 16'd25);
    check("tie_second_id", {15'd0, bus_if.prod_id}, 16'd1);
    check("tie_second_excl", {15'd0, bus_if.done0}, 16'd0);
    bus_if.req1 = 1'b0;
    tick();

    // tie again: last grant was 1, so requester 0 wins
    bus_if.req0 = 1'b1;
    bus_if.req1 = 1'b1;
    wait_done(1'b0, edges);
    check("tie_again_lat", 16'(edges), 16'd3);
    check("tie_again_prod", {8'd0, bus_if.prod}, 16'd15);
    check("tie_again_id", {15'd0, bus_if.prod_id}, 16'd0);
    set_req(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();

    // req1 held: 225 every 4 cycles
    set_req(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd15);
    wait_done(1'b1, edges);
    check("hold_first_lat", 16'(edges), 16'd3);
    check("hold_first_prod", {8'd0, bus_if.prod}, 16'd225);
    for (int k = 0; k < 2; k++) begin
      wait_done(1'b1, edges);
      check("hold_period", 16'(edges), 16'd4);
      check("hold_prod", {8'd0, bus_if.prod}, 16'd225);
      check("hold_id", {15'd0, bus_if.prod_id}, 16'd1);
    end
    bus_if.req1 = 1'b0;
    tick();

    // operand change during BUSY is ignored
    set_req(1'b1, 4'd3, 4'd2, 1'b0, 4'd0, 4'd0);
    tick();
    check("inflight_busy", {15'd0, bus_if.busy}, 16'd1);
    bus_if.a0 = 4'd7;
    wait_done(1'b0, edges);
    check("inflight_lat", 16'(edges), 16'd2);
    check("inflight_prod", {8'd0, bus_if.prod}, 16'd6);
    bus_if.req0 = 1'b0;
    tick();

    // zero operand
    set_req(1'b1, 4'd0, 4'd9, 1'b0, 4'd0, 4'd0);
    wait_done(1'b0, edges);
    check("zero_lat", 16'(edges), 16'd3);
    check("zero_prod", {8'd0, bus_if.prod}, 16'd0);
    check("zero_valid", {15'd0, bus_if.prod_valid}, 16'd1);
    bus_if.req0 = 1'b0;
    tick();

    // tie with last grant 0: requester 1 wins
    set_req(1'b1, 4'd2, 4'd2, 1'b1, 4'd3, 4'd4);
    wait_done(1'b1, edges);
    check("tie_rr_lat", 16'(edges), 16'd3);
    check("tie_rr_prod", {8'd0, bus_if.prod}, 16'd12);
    check("tie_rr_id", {15'd0, bus_if.prod_id}, 16'd1);
    set_req(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    tick();

    // reset one cycle into BUSY aborts the operation
    set_req(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 4'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", {15'd0, bus_if.busy}, 16'd0);
    check("abort_prod", {8'd0, bus_if.prod}, 16'd0);
    check("abort_done0", {15'd0, bus_if.done0}, 16'd0);
    bus_if.req0 = 1'b0;
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus_if.done0 === 1'b1 || bus_if.done1 === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", {15'd0, saw_done}, 16'd0);
    check("abort_idle", {14'd0, bus_if.dbg_state}, 16'd0);
    check("abort_prod_after", {8'd0, bus_if.prod}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
